calc_seq: RTL and testbench

- Sequential, parametrised successor to the combinational add/sub datapath in the calculator.
- Executes add, subtract, unsigned multiply and unsigned divide on two n-bit operands.
- Add/sub complete in one cycle; mul/div run as n-iteration shift-add / restoring-divide loops.
- Start/busy/done handshake plus status flags; sits between the calculator's operand registers and its display/result logic.

---
 rtl/calc_seq_if.sv | 27 ++
 rtl/calc_seq.sv | 162 ++++++++++++++++
 tb/tb_calc_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/calc_seq_if.sv
// Operand/result bus for calc_seq: start/busy/done handshake, operands,
// result word and status flags. master = requester, slave = calc_seq.
interface calc_seq_if #(
  parameter int n = 4
);
  logic           start;
  logic [1:0]     op;
  logic [n-1:0]   a;
  logic [n-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*n-1:0] s;
  logic           cout;
  logic           ovf;
  logic           zero;
  logic           dbz;

  modport master (
    output start, op, a, b,
    input  busy, done, s, cout, ovf, zero, dbz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, s, cout, ovf, zero, dbz
  );
endinterface

// File: rtl/calc_seq.sv
// calc_seq: sequential add/sub/mul/div on two n-bit unsigned operands.
// add/sub and divide-by-zero complete at the accepting edge; mul (shift-add)
// and div (restoring) iterate n cycles in RUN.
// Optional macro CALC_SAT_EN: add/sub saturate instead of wrapping.
module calc_seq #(
  parameter int n = 4
) (
  input logic        clk,
  input logic        rst_n,
  calc_seq_if.slave  bus
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic           r_op_div;
  logic [n-1:0]   r_hi;
  logic [n-1:0]   r_lo;
  logic [n-1:0]   r_b;

  logic [2*n-1:0] r_s;
  logic           r_cout;
  logic           r_ovf;
  logic           r_zero;
  logic           r_dbz;
  logic           r_done;

  logic           w_accept;
  logic           w_is_sub;
  logic           w_is_dbz;
  logic           w_last;
  logic [n-1:0]   w_b_eff;
  logic [n:0]     w_as;
  logic           w_as_ovf;
  logic [n-1:0]   w_as_res;
  logic [n:0]     w_madd;
  logic [n:0]     w_trial;
  logic [n-1:0]   w_it_hi;
  logic [n-1:0]   w_it_lo;

  assign w_accept = bus.start && (r_state == IDLE);
  assign w_is_sub = (bus.op == 2'b01);
  assign w_is_dbz = (bus.op == 2'b11) && (bus.b == '0);
  assign w_last   = (r_cnt == CW'(1));

  // add/sub share one adder: sub is a + ~b + 1
  always_comb begin
    w_b_eff  = w_is_sub ? ~bus.b : bus.b;
    w_as     = {1'b0, bus.a} + {1'b0, w_b_eff} + {{n{1'b0}}, w_is_sub};
    w_as_ovf = (bus.a[n-1] == w_b_eff[n-1]) && (w_as[n-1] != bus.a[n-1]);
    w_as_res = w_as[n-1:0];
`ifdef CALC_SAT_EN
    // carry out on add means overflow past all-ones; no carry on sub means a < b
    if (!w_is_sub && w_as[n]) w_as_res = '1;
    if (w_is_sub && !w_as[n]) w_as_res = '0;
`endif
  end

  // one mul or div iteration on {r_hi, r_lo}
  always_comb begin
    // mul: r_b = multiplicand, r_lo = multiplier shifting out LSB-first
    w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // div: r_hi = partial remainder, r_lo = dividend shifting into quotient
    w_trial = {r_hi, r_lo[n-1]} - {1'b0, r_b};
    if (!r_op_div) begin
      w_it_hi = w_madd[n:1];
      w_it_lo = {w_madd[0], r_lo[n-1:1]};
    end else if (!w_trial[n]) begin
      w_it_hi = w_trial[n-1:0];
      w_it_lo = {r_lo[n-2:0], 1'b1};
    end else begin
      w_it_hi = {r_hi[n-2:0], r_lo[n-1]};
      w_it_lo = {r_lo[n-2:0], 1'b0};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: only mul and non-zero div enter RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept && bus.op[1] && !w_is_dbz) w_state_nxt = RUN;
      RUN:  if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // datapath, iteration counter and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (!bus.op[1]) begin
          r_s    <= {{n{1'b0}}, w_as_res};
          r_cout <= w_as[n];
          r_ovf  <= w_as_ovf;
          r_zero <= (w_as_res == '0);
          r_dbz  <= 1'b0;
          r_done <= 1'b1;
        end else if (w_is_dbz) begin
          r_s    <= {bus.a, {n{1'b1}}};
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
          r_dbz  <= 1'b1;
          r_done <= 1'b1;
        end else begin
          r_op_div <= bus.op[0];
          r_cnt    <= CW'(n);
          r_hi     <= '0;
          r_lo     <= bus.op[0] ? bus.a : bus.b;
          r_b      <= bus.op[0] ? bus.b : bus.a;
        end
      end else if (r_state == RUN) begin
        r_hi  <= w_it_hi;
        r_lo  <= w_it_lo;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_s    <= {w_it_hi, w_it_lo};
          r_cout <= 1'b0;
          r_ovf  <= !r_op_div && (w_it_hi != '0);
          r_zero <= ({w_it_hi, w_it_lo} == '0);
          r_dbz  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;
  assign bus.dbz  = r_dbz;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq (n=4): directed cases plus random ops
// against an arithmetic reference model.
module tb_calc_seq;

  localparam int N = 4;
  localparam int M = 1 << N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  calc_seq_if #(.n(N)) u_if ();

  calc_seq #(.n(N)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  longint      last_s   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference: plain integer arithmetic on the operand values
  task automatic model(input logic [1:0] op, input int a, input int b,
                       output longint es, output bit ec, output bit eo,
                       output bit ez, output bit ed, output int lat);
    int sa, sb, t;
    sa  = (a >= M / 2) ? a - M : a;
    sb  = (b >= M / 2) ? b - M : b;
    ec  = 1'b0;
    eo  = 1'b0;
    ed  = 1'b0;
    lat = 1;
    es  = 0;
    case (op)
      2'b00: begin
        t  = a + b;
        ec = (t >= M);
        es = t % M;
        eo = ((sa + sb) > M / 2 - 1) || ((sa + sb) < -(M / 2));
`ifdef CALC_SAT_EN
        if (ec) es = M - 1;
`endif
      end
      2'b01: begin
        ec = (a >= b);
        es = (a - b + M) % M;
        eo = ((sa - sb) > M / 2 - 1) || ((sa - sb) < -(M / 2));
`ifdef CALC_SAT_EN
        if (!ec) es = 0;
`endif
      end
      2'b10: begin
        es  = a * b;
        eo  = (es >= M);
        lat = N + 1;
      end
      default: begin
        if (b == 0) begin
          es = a * M + (M - 1);
          ed = 1'b1;
        end else begin
          es  = (a % b) * M + (a / b);
          lat = N + 1;
        end
      end
    endcase
    ez = (es == 0) && !ed;
  endtask

  // Call just after a negedge; returns at the negedge where done is seen.
  // poke=1 pulses start with different operands while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input int a,
                        input int b, input bit poke);
    longint es;
    bit ec, eo, ez, ed;
    int lat, cycles, busy_cnt;
    model(op, a, b, es, ec, eo, ez, ed, lat);
    u_if.start = 1'b1;
    u_if.op    = op;
    u_if.a     = N'(a);
    u_if.b     = N'(b);
    @(negedge clk);
    u_if.start = 1'b0;
    cycles   = 1;
    busy_cnt = 0;
    while (!u_if.done && cycles < 40) begin
      if (u_if.busy) busy_cnt++;
      if (poke && cycles == 2) begin
        u_if.start = 1'b1;
        u_if.op    = 2'b00;
        u_if.a     = N'(a + 5);
        u_if.b     = N'(b + 3);
      end else begin
        u_if.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    u_if.start = 1'b0;
    check({tag, ".latency"}, cycles, lat);
    check({tag, ".busy_cycles"}, busy_cnt, lat - 1);
    check({tag, ".busy_at_done"}, u_if.busy, 0);
    check({tag, ".s"}, u_if.s, es);
    check({tag, ".cout"}, u_if.cout, ec);
    check({tag, ".ovf"}, u_if.ovf, eo);
    check({tag, ".zero"}, u_if.zero, ez);
    check({tag, ".dbz"}, u_if.dbz, ed);
    last_s = es;
  endtask

  // one idle cycle: done must have dropped and the result must hold
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, ".done_pulse"}, u_if.done, 0);
    check({tag, ".hold_s"}, u_if.s, last_s);
  endtask

  initial begin
    bit any_done;
    u_if.start = 1'b0;
    u_if.op    = 2'b00;
    u_if.a     = '0;
    u_if.b     = '0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.s", u_if.s, 0);
    check("reset.flags", {u_if.busy, u_if.done, u_if.cout, u_if.ovf, u_if.zero, u_if.dbz}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_1_2", 2'b00, 1, 2, 1'b0);
    idle_check("add_1_2");
    run_op("add_15_1", 2'b00, 15, 1, 1'b0);
    idle_check("add_15_1");
    run_op("sub_5_11", 2'b01, 5, 11, 1'b0);
    idle_check("sub_5_11");
    run_op("mul_15_15_poke", 2'b10, 15, 15, 1'b1);
    idle_check("mul_15_15_poke");
    run_op("div_9_6", 2'b11, 9, 6, 1'b0);
    run_op("div_9_0_b2b", 2'b11, 9, 0, 1'b0);
    idle_check("div_9_0");
    run_op("sub_7_7", 2'b01, 7, 7, 1'b0);
    run_op("add_7_1", 2'b00, 7, 1, 1'b0);
    run_op("mul_0_9", 2'b10, 0, 9, 1'b0);
    run_op("div_0_3", 2'b11, 0, 3, 1'b0);
    run_op("div_9_0_again", 2'b11, 9, 0, 1'b0);
    idle_check("pre_reset");

    // abort a multiply with reset part-way through
    u_if.start = 1'b1;
    u_if.op    = 2'b10;
    u_if.a     = N'(7);
    u_if.b     = N'(5);
    @(negedge clk);
    u_if.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.s", u_if.s, 0);
    check("abort.flags", {u_if.busy, u_if.done, u_if.cout, u_if.ovf, u_if.zero, u_if.dbz}, 0);
    any_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (u_if.done) any_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (N + 2) begin
      @(negedge clk);
      if (u_if.done || u_if.busy) any_done = 1'b1;
    end
    check("abort.no_done", any_done, 0);
    run_op("post_reset_add", 2'b00, 1, 2, 1'b0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) idle_check("rand_idle");
      run_op("rand", 2'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, M - 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
